// File: rtl/rca_sweep_bist.sv
// rca_sweep_bist: exhaustive operand sweep BIST for a ripple-carry adder/subtractor.
// Drives registered operands {b_out,a_out} = vec with a latched carry-in, waits
// SETTLE_CYCLES clocks per vector, then compares {cout_in,sum_in} against a golden
// model (MODE 0: a+b+cin, MODE 1: a+~b+cin) and accumulates a saturating error count.
// Optional build macro RCA_SWEEP_BIST_STOP_ON_FAIL_EN: stop at the first mismatch and
// hold the failing operands on a_out/b_out.
module rca_sweep_bist #(
    parameter int WIDTH         = 8,
    parameter int MODE          = 0,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cin_sel,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 cin_out,
    input  logic [WIDTH-1:0]     sum_in,
    input  logic                 cout_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH-1:0]   err_count,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam int VW = 2 * WIDTH;
    localparam int EW = WIDTH + 1;
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [VW-1:0]     r_vec;
    logic [3:0]        r_wait;
    logic              r_cin;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [VW-1:0]     r_err;
    logic [WIDTH-1:0]  r_fail_a;
    logic [WIDTH-1:0]  r_fail_b;

    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_b_eff;
    logic [EW-1:0]     w_exp;
    logic              w_mis;
    logic [VW-1:0]     w_err_next;
    logic              w_last;

    assign w_a = r_vec[WIDTH-1:0];
    assign w_b = r_vec[VW-1:WIDTH];

    // Golden model and per-vector compare; error count saturates at all-ones
    always_comb begin
        w_b_eff    = (MODE == 1) ? ~w_b : w_b;
        w_exp      = {1'b0, w_a} + {1'b0, w_b_eff} + EW'(r_cin);
        w_mis      = (w_exp != {cout_in, sum_in});
        w_err_next = r_err;
        if (w_mis && !(&r_err)) begin
            w_err_next = r_err + VW'(1);
        end
        w_last     = &r_vec;
    end

    // Sweep sequencer: IDLE/DONE accept start, WAIT settles, CHECK compares and advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_wait   <= '0;
            r_cin    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fail_a <= '0;
            r_fail_b <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_vec    <= '0;
                        r_cin    <= cin_sel;
                        r_err    <= '0;
                        r_fail_a <= '0;
                        r_fail_b <= '0;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_wait   <= SETTLE;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_wait <= r_wait - 4'd1;
                    if (r_wait == 4'd1) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mis && (r_err == '0)) begin
                        r_fail_a <= w_a;
                        r_fail_b <= w_b;
                    end
`ifdef RCA_SWEEP_BIST_STOP_ON_FAIL_EN
                    if (w_mis || w_last) begin
`else
                    if (w_last) begin
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + VW'(1);
                        r_wait  <= SETTLE;
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_out     = w_a;
    assign b_out     = w_b;
    assign cin_out   = r_cin;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;

endmodule

// File: tb/tb_rca_sweep_bist.sv
// Bench for rca_sweep_bist at WIDTH=4: one MODE 0 and one MODE 1 instance, each
// driven by a behavioural adder with selectable planted faults. Expected sweep
// results are queued at start and compared when done rises.
module tb_rca_sweep_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_p = 1'b0;
    logic        cin_sel = 1'b0;
    int unsigned tb_sel  = 0;
    int unsigned fault0  = 0;
    int unsigned fault1  = 0;

    logic       start0, start1;
    logic [3:0] a0, b0, s0, fa0, fb0;
    logic [3:0] a1, b1, s1, fa1, fb1;
    logic       c0, c1, co0, co1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] err0, err1;
    logic [4:0] res0, res1;

    assign start0 = start_p && (tb_sel == 0);
    assign start1 = start_p && (tb_sel == 1);

    rca_sweep_bist #(.WIDTH(4), .MODE(0), .SETTLE_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .cin_sel(cin_sel),
        .a_out(a0), .b_out(b0), .cin_out(c0), .sum_in(s0), .cout_in(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_a(fa0), .fail_b(fb0)
    );

    rca_sweep_bist #(.WIDTH(4), .MODE(1), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .cin_sel(cin_sel),
        .a_out(a1), .b_out(b1), .cin_out(c1), .sum_in(s1), .cout_in(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_a(fa1), .fail_b(fb1)
    );

    // Adders under test: fault 1 = sum bit 2 stuck at 0, fault 3 = cout inverted,
    // fault 2 = sum bit 0 flipped only at a=3, b=5 (difference adder)
    always_comb begin
        res0 = {1'b0, a0} + {1'b0, b0} + 5'(c0);
        if (fault0 == 1) res0[2] = 1'b0;
        if (fault0 == 3) res0[4] = ~res0[4];
        res1 = {1'b0, a1} + {1'b0, ~b1} + 5'(c1);
        if (fault1 == 2 && a1 == 4'd3 && b1 == 4'd5) res1[0] = ~res1[0];
    end
    assign {co0, s0} = res0;
    assign {co1, s1} = res1;

    // Observation mux for the instance under test
    logic       m_busy, m_done, m_pass, m_cin;
    logic [3:0] m_a, m_b, m_fa, m_fb;
    logic [7:0] m_err;
    always_comb begin
        m_busy = (tb_sel == 1) ? busy1 : busy0;
        m_done = (tb_sel == 1) ? done1 : done0;
        m_pass = (tb_sel == 1) ? pass1 : pass0;
        m_cin  = (tb_sel == 1) ? c1    : c0;
        m_a    = (tb_sel == 1) ? a1    : a0;
        m_b    = (tb_sel == 1) ? b1    : b0;
        m_fa   = (tb_sel == 1) ? fa1   : fa0;
        m_fb   = (tb_sel == 1) ? fb1   : fb0;
        m_err  = (tb_sel == 1) ? err1  : err0;
    end

    typedef struct {
        int unsigned lat;
        logic [7:0]  err;
        logic        pass;
        logic [3:0]  fa, fb, ea, eb;
    } exp_t;

    exp_t sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input int unsigned lat, input logic [7:0] err, input logic p,
                                input logic [3:0] fa, input logic [3:0] fb,
                                input logic [3:0] ea, input logic [3:0] eb);
        exp_t e;
        e.lat = lat; e.err = err; e.pass = p;
        e.fa = fa; e.fb = fb; e.ea = ea; e.eb = eb;
        return e;
    endfunction

    task automatic run_sweep(input int unsigned sel, input logic cinv, input int unsigned fault,
                             input bit dup, input exp_t e);
        int unsigned lat;
        exp_t got;
        tb_sel = sel;
        if (sel == 1) fault1 = fault; else fault0 = fault;
        cin_sel = cinv;
        sb_q.push_back(e);
        @(posedge clk); #1 start_p = 1'b1;
        @(posedge clk); #1 start_p = 1'b0;
        check_eq("acc_busy", 32'(m_busy), 32'd1);
        check_eq("acc_done_clr", 32'(m_done), 32'd0);
        check_eq("acc_cin", 32'(m_cin), 32'(cinv));
        check_eq("acc_vec0", 32'({m_b, m_a}), 32'd0);
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            start_p = dup && (lat == 100);
            if (m_done) break;
        end
        start_p = 1'b0;
        got = sb_q.pop_front();
        check_eq("latency", lat, got.lat);
        check_eq("err_count", 32'(m_err), 32'(got.err));
        check_eq("pass", 32'(m_pass), 32'(got.pass));
        check_eq("fail_ab", 32'({m_fb, m_fa}), 32'({got.fb, got.fa}));
        check_eq("final_ab", 32'({m_b, m_a}), 32'({got.eb, got.ea}));
        check_eq("busy_clr", 32'(m_busy), 32'd0);
    endtask

    localparam logic [3:0] F = 4'hF;

`ifdef RCA_SWEEP_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    initial begin
        bit found;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ab0", 32'({b0, a0, c0}), 32'd0);
        check_eq("rst_stat0", 32'({busy0, done0, pass0}), 32'd0);
        check_eq("rst_err0", 32'(err0), 32'd0);
        check_eq("rst_fail0", 32'({fb0, fa0}), 32'd0);
        check_eq("rst_all1", 32'({b1, a1, c1, busy1, done1, pass1, err1, fb1, fa1}), 32'd0);
        rst = 1'b0;

        // Correct adder, both carry-in values
        run_sweep(0, 1'b0, 0, 1'b0, mk(512, 8'd0, 1'b1, 4'd0, 4'd0, F, F));
        run_sweep(0, 1'b1, 0, 1'b0, mk(512, 8'd0, 1'b1, 4'd0, 4'd0, F, F));

        // Sum bit 2 stuck at 0: first failure at a=4, b=0
        if (STOP) run_sweep(0, 1'b0, 1, 1'b0, mk(10, 8'd1, 1'b0, 4'd4, 4'd0, 4'd4, 4'd0));
        else      run_sweep(0, 1'b0, 1, 1'b0, mk(512, 8'd128, 1'b0, 4'd4, 4'd0, F, F));

        // Every vector wrong: 256 mismatches saturate at 255
        if (STOP) run_sweep(0, 1'b0, 3, 1'b0, mk(2, 8'd1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0));
        else      run_sweep(0, 1'b0, 3, 1'b0, mk(512, 8'd255, 1'b0, 4'd0, 4'd0, F, F));

        // Start while busy is ignored
        run_sweep(0, 1'b0, 0, 1'b1, mk(512, 8'd0, 1'b1, 4'd0, 4'd0, F, F));

        // Asynchronous reset mid-sweep at vec=0x37
        tb_sel = 0; fault0 = 0; cin_sel = 1'b0;
        @(posedge clk); #1 start_p = 1'b1;
        @(posedge clk); #1 start_p = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ({b0, a0} == 8'h37) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("reach_37", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_ab", 32'({b0, a0, c0}), 32'd0);
        check_eq("mid_rst_stat", 32'({busy0, done0, pass0}), 32'd0);
        check_eq("mid_rst_err", 32'({err0, fb0, fa0}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        run_sweep(0, 1'b0, 0, 1'b0, mk(512, 8'd0, 1'b1, 4'd0, 4'd0, F, F));

        // Difference form: correct, then a single wrong result at a=3, b=5
        run_sweep(1, 1'b1, 0, 1'b0, mk(512, 8'd0, 1'b1, 4'd0, 4'd0, F, F));
        if (STOP) run_sweep(1, 1'b1, 2, 1'b0, mk(168, 8'd1, 1'b0, 4'd3, 4'd5, 4'd3, 4'd5));
        else      run_sweep(1, 1'b1, 2, 1'b0, mk(512, 8'd1, 1'b0, 4'd3, 4'd5, F, F));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rca_sweep_bist.md
Name: rca_sweep_bist

Overview:
- Self-checking operand sequencer that sits on both sides of the ripple-carry adder/subtractor stage.
- Upstream, it drives registered operands a/b/cin into the adder.
- Downstream, it consumes the adder's sum/cout and compares them against an internal golden model.
- It sweeps every {b,a} combination exhaustively, turning the simulation-only exhaustive sweep into synthesizable on-chip BIST.

Parameters:
WIDTH, 8, operand width of the adder under test.
MODE, 0, golden model: 0 = a + b + cin; 1 = a + ~b + cin (difference form).
SETTLE_CYCLES, 1, clocks to wait after an operand change before sampling sum/cout (legal range 1..15).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a sweep when idle or done.
cin_sel  in  1  carry-in value used for the sweep; latched on an accepted start.
a_out  out  WIDTH  operand A to the adder (registered).
b_out  out  WIDTH  operand B to the adder (registered).
cin_out  out  1  carry-in to the adder (registered).
sum_in  in  WIDTH  adder sum.
cout_in  in  1  adder carry-out.
busy  out  1  high while a sweep is in progress.
done  out  1  high from sweep completion until the next accepted start.
pass  out  1  valid when done is high; 1 iff err_count == 0.
err_count  out  2*WIDTH  saturating mismatch count.
fail_a  out  WIDTH  A operand of the first mismatch.
fail_b  out  WIDTH  B operand of the first mismatch.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - a_out, b_out, cin_out, busy, done, pass, err_count, fail_a, fail_b all reset to 0.
  - A reset mid-sweep abandons the sweep; no partial result is retained.
- Internal vector counter vec, 2*WIDTH bits. Operand mapping: {b_out,a_out} = vec.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE / DONE:
  - When start=1: vec←0, cin_out←cin_sel, err_count←0, fail_a/fail_b←0, done←0, pass←0, busy←1, wait counter←SETTLE_CYCLES, go to WAIT.
  - start while in WAIT or CHECK is ignored.
- WAIT:
  - The wait counter decrements each clock.
  - On the cycle the counter reaches 1, go to CHECK. This gives exactly SETTLE_CYCLES cycles in WAIT.
- CHECK:
  - Compute expected = (WIDTH+1)-bit result of the MODE expression using a_out, b_out, cin_out.
  - Compare expected against {cout_in,sum_in}.
  - On mismatch: err_count increments, saturating at all-ones.
  - On the first mismatch (err_count == 0 before the increment): latch fail_a←a_out and fail_b←b_out.
  - If vec == all-ones: go to DONE; busy←0, done←1, pass←(final err_count == 0). The final err_count includes the current compare.
  - Otherwise: vec←vec+1 (operands update on this same edge), reload the wait counter, go to WAIT.
- Per-vector cost is SETTLE_CYCLES+1 clocks. Total sweep is 2^(2*WIDTH)·(SETTLE_CYCLES+1) clocks from start acceptance to done rising.
- Wrap-around: vec never wraps; the all-ones vector is the last one checked.
- Arithmetic: golden model is computed at WIDTH+1 bits, with no sign extension. In MODE 1, ~b is the WIDTH-bit complement.
- Simultaneous start and completion: the CHECK→DONE transition takes priority; start is sampled only in IDLE/DONE.
- Operand, cin and status outputs are registered; no combinational path from sum_in/cout_in to any output.

Optional Feature:
- Macro: RCA_SWEEP_BIST_STOP_ON_FAIL_EN.
- When defined:
  - The first mismatch in CHECK goes directly to DONE: busy←0, done←1, pass←0, err_count=1.
  - a_out/b_out remain frozen at the failing vector so it can be probed.
- When undefined:
  - The sweep always runs to the all-ones vector, counting every mismatch.

Test Plan:
- WIDTH=4, MODE=0, correct adder model, cin_sel=0, start pulse → done rises exactly 256·2=512 clocks after acceptance; pass=1, err_count=0.
- WIDTH=4, MODE=1, correct difference model, cin_sel=1 → pass=1. Sample check: a=3, b=5 expects {cout,sum}=5'b01110.
- WIDTH=4, MODE=0, adder with sum bit 2 stuck at 0 → pass=0, fail_a=4, fail_b=0, err_count=128.
- Same faulty adder with RCA_SWEEP_BIST_STOP_ON_FAIL_EN defined → done after 5·2=10 clocks, err_count=1, a_out=4, b_out=0 held.
- Assert rst at mid-sweep (vec=0x37) → all outputs 0 and state IDLE immediately (asynchronous). A new start restarts from vec=0.
- start pulsed while busy → ignored: vec is not reset and completion time is unchanged. start in DONE → done clears next cycle, new sweep begins.
